openofdm_rx_reg_bank: RTL and testbench

Parametrised AXI4-Lite register bank for the OpenOFDM receiver. It replaces the fixed 5-config/1-status register slave with a configurable number of read/write configuration registers and read-only status registers. It adds byte-strobe writes, self-clearing pulse bits (e.g. soft reset of the dot11 core) and per-register write/read strobes. It sits between the PS AXI interconnect and the dot11 core, inside the openofdm_rx top level.

---
 rtl/openofdm_rx_reg_bank.sv | 212 +++++++++++++++++++++
 tb/tb_openofdm_rx_reg_bank.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openofdm_rx_reg_bank.sv
// AXI4-Lite register bank for the OpenOFDM receiver: byte-strobed R/W config registers,
// self-clearing pulse bits in config reg 0, read-only status registers and per-register strobes.
//
// state  | meaning
// W_IDLE | waiting for AW and W together
// W_ACK  | awready/wready high, write committed at the closing edge
// W_RESP | bvalid high with stable bresp until bready
// R_IDLE | waiting for arvalid
// R_ACK  | arready high, rdata/rresp captured at the closing edge
// R_DATA | rvalid high with stable rdata/rresp until rready
module openofdm_rx_reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    N_CFG      = 20,
    parameter int                    N_STAT     = 12,
    parameter logic [DATA_WIDTH-1:0] PULSE_MASK = 'h1,
    parameter int                    PULSE_LEN  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [N_CFG*DATA_WIDTH-1:0]  cfg_flat,
    output logic [N_CFG-1:0]             cfg_wr_stb,
    input  logic [N_STAT*DATA_WIDTH-1:0] stat_flat,
    output logic [N_STAT-1:0]            stat_rd_stb
);

    localparam int             NB          = DATA_WIDTH / 8;
    localparam int             CW          = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0]  L_PLEN      = CW'(PULSE_LEN);
    localparam logic [31:0]    L_NCFG      = 32'(N_CFG);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} r_state_t;

    w_state_t              r_wstate, w_wstate_nxt;
    r_state_t              r_rstate, w_rstate_nxt;
    logic [DATA_WIDTH-1:0] r_cfg [N_CFG];
    logic [CW-1:0]         r_pulse_cnt;
    logic [N_CFG-1:0]      r_cfg_wr_stb;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [N_STAT-1:0]     r_stat_rd_stb;

    logic [31:0]           w_aw_idx;
    logic [31:0]           w_ar_idx;
    logic [DATA_WIDTH-1:0] w_wmask;
    logic                  w_commit;
    logic                  w_wr_cfg;
    logic                  w_pulse_set;
    logic                  w_pulse_expire;
    logic [DATA_WIDTH-1:0] w_cfg0_base;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [N_STAT-1:0]     w_rd_stat;
    logic                  w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign w_aw_idx = 32'(s_axi_awaddr[ADDR_WIDTH-1:2]);
    assign w_ar_idx = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);

    always_comb begin
        w_wmask = '0;
        for (int k = 0; k < NB; k++) w_wmask[k*8 +: 8] = {8{s_axi_wstrb[k]}};
    end

    assign w_commit       = (r_wstate == W_ACK);
    assign w_wr_cfg       = (w_aw_idx < L_NCFG);
    assign w_pulse_set    = w_commit && (w_aw_idx == 32'd0) && (|(s_axi_wdata & w_wmask & PULSE_MASK));
    assign w_pulse_expire = (r_pulse_cnt == CW'(1));
    // An expiring pulse and a same-edge write to reg 0 merge: the write wins on the lanes it enables.
    assign w_cfg0_base    = w_pulse_expire ? (r_cfg[0] & ~PULSE_MASK) : r_cfg[0];

    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_wstate_nxt = W_ACK;
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                w_wstate_nxt  = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: if (s_axi_arvalid) w_rstate_nxt = R_ACK;
            R_ACK: begin
                s_axi_arready = 1'b1;
                w_rstate_nxt  = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        w_rd_stat = '0;
        for (int i = 0; i < N_CFG; i++) begin
            if (w_ar_idx == 32'(i)) begin
                w_rd_data = r_cfg[i];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (w_ar_idx == 32'(N_CFG + j)) begin
                w_rd_data    = stat_flat[j*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp    = RESP_OKAY;
                w_rd_stat[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CFG; i++) r_cfg[i] <= '0;
            r_pulse_cnt  <= '0;
            r_cfg_wr_stb <= '0;
            r_bresp      <= RESP_OKAY;
        end else begin
            r_cfg_wr_stb <= '0;
            if (r_pulse_cnt != '0) r_pulse_cnt <= r_pulse_cnt - CW'(1);
            if (w_pulse_expire) r_cfg[0] <= w_cfg0_base;
            if (w_commit) begin
                r_bresp <= w_wr_cfg ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < N_CFG; i++) begin
                    if (w_aw_idx == 32'(i)) begin
                        r_cfg[i]        <= (((i == 0) ? w_cfg0_base : r_cfg[i]) & ~w_wmask)
                                           | (s_axi_wdata & w_wmask);
                        r_cfg_wr_stb[i] <= 1'b1;
                    end
                end
            end
            if (w_pulse_set) r_pulse_cnt <= L_PLEN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata       <= '0;
            r_rresp       <= RESP_OKAY;
            r_stat_rd_stb <= '0;
        end else begin
            r_stat_rd_stb <= '0;
            if (r_rstate == R_ACK) begin
                r_rdata       <= w_rd_data;
                r_rresp       <= w_rd_resp;
                r_stat_rd_stb <= w_rd_stat;
            end
        end
    end

    for (genvar i = 0; i < N_CFG; i++) begin : g_cfg_flat
        assign cfg_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_cfg[i];
    end

    assign cfg_wr_stb  = r_cfg_wr_stb;
    assign s_axi_bresp = r_bresp;
    assign s_axi_rdata = r_rdata;
    assign s_axi_rresp = r_rresp;
    assign stat_rd_stb = r_stat_rd_stb;

endmodule

// File: tb/tb_openofdm_rx_reg_bank.sv
// Bench for openofdm_rx_reg_bank: default-parameter instance plus a small (4 cfg / 2 stat)
// instance sharing the AXI request signals, checked against a register-map model.
module tb_openofdm_rx_reg_bank;

    localparam int NC  = 20;
    localparam int NS  = 12;
    localparam int NCS = 4;
    localparam int NSS = 2;
    localparam int PL  = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [6:0]  s_axi_awaddr, s_axi_araddr;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;

    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic [NC*32-1:0] cfg_flat;
    logic [NC-1:0]    cfg_wr_stb;
    logic [NS*32-1:0] stat_flat;
    logic [NS-1:0]    stat_rd_stb;

    logic        awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
    logic [1:0]  bresp_s, rresp_s;
    logic [31:0] rdata_s;
    logic [NCS*32-1:0] cfg_flat_s;
    logic [NCS-1:0]    cfg_wr_stb_s;
    logic [NSS*32-1:0] stat_flat_s;
    logic [NSS-1:0]    stat_rd_stb_s;

    openofdm_rx_reg_bank dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .cfg_flat(cfg_flat), .cfg_wr_stb(cfg_wr_stb),
        .stat_flat(stat_flat), .stat_rd_stb(stat_rd_stb)
    );

    openofdm_rx_reg_bank #(.N_CFG(NCS), .N_STAT(NSS)) dut_s (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(awready_s), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(wready_s), .s_axi_bresp(bresp_s),
        .s_axi_bvalid(bvalid_s), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(arready_s),
        .s_axi_rdata(rdata_s), .s_axi_rresp(rresp_s), .s_axi_rvalid(rvalid_s),
        .s_axi_rready(s_axi_rready), .cfg_flat(cfg_flat_s), .cfg_wr_stb(cfg_wr_stb_s),
        .stat_flat(stat_flat_s), .stat_rd_stb(stat_rd_stb_s)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic hist [16384];
    always @(negedge clock) if (cyc < 16384) hist[cyc] = cfg_flat[0];

    // Reference register map
    logic [31:0] m_cfg   [NC];
    logic [31:0] m_cfg_s [NCS];
    logic [31:0] m_stat  [NS];
    logic [31:0] m_stat_s[NSS];

    typedef struct { int vis; logic val; } pulse_ev_t;
    pulse_ev_t pq[$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (st[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cfg[i] = '0;
        for (int i = 0; i < NCS; i++) m_cfg_s[i] = '0;
    endtask

    task automatic model_write(input logic [6:0] addr, input logic [31:0] d, input logic [3:0] st);
        int idx = int'(addr[6:2]);
        if (idx < NC) m_cfg[idx] = merge(m_cfg[idx], d, st);
        if (idx < NCS) m_cfg_s[idx] = merge(m_cfg_s[idx], d, st);
    endtask

    task automatic exp_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        if (idx < NC) begin d = m_cfg[idx]; r = 2'b00; end
        else if (idx < NC + NS) begin d = m_stat[idx - NC]; r = 2'b00; end
        else begin d = '0; r = 2'b10; end
    endtask

    task automatic exp_read_s(input int idx, output logic [31:0] d, output logic [1:0] r);
        if (idx < NCS) begin d = m_cfg_s[idx]; r = 2'b00; end
        else if (idx < NCS + NSS) begin d = m_stat_s[idx - NCS]; r = 2'b00; end
        else begin d = '0; r = 2'b10; end
    endtask

    task automatic load_stat();
        for (int j = 0; j < NS; j++) stat_flat[j*32 +: 32] = m_stat[j];
        for (int j = 0; j < NSS; j++) stat_flat_s[j*32 +: 32] = m_stat_s[j];
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp, output logic [1:0] resp_s, output int lat,
                             output logic bv, output int vis, output logic [NC*32-1:0] cfg_ack,
                             output logic [NC*32-1:0] cfg_vis, output logic [NC-1:0] stb_vis,
                             output logic [NC-1:0] stb_next);
        s_axi_awaddr = addr; s_axi_wdata = d; s_axi_wstrb = st;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        lat = 0;
        do begin @(negedge clock); lat++; end while (!(s_axi_awready && s_axi_wready) && lat < 16);
        cfg_ack = cfg_flat;
        @(negedge clock);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        bv = s_axi_bvalid; resp = s_axi_bresp; resp_s = bresp_s; vis = cyc;
        cfg_vis = cfg_flat; stb_vis = cfg_wr_stb;
        s_axi_bready = 1'b1;
        @(negedge clock);
        s_axi_bready = 1'b0;
        stb_next = cfg_wr_stb;
    endtask

    task automatic axi_read(input logic [6:0] addr, input int rdelay,
                            output logic [31:0] d, output logic [1:0] r,
                            output logic [31:0] d_s, output logic [1:0] r_s, output int lat,
                            output logic stable, output logic [NS-1:0] stb_first, output int stb_cnt);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        lat = 0;
        do begin @(negedge clock); lat++; end while (!s_axi_arready && lat < 16);
        @(negedge clock);
        s_axi_arvalid = 1'b0;
        d = s_axi_rdata; r = s_axi_rresp; d_s = rdata_s; r_s = rresp_s;
        stable = s_axi_rvalid;
        stb_first = stat_rd_stb;
        stb_cnt = $countones(stat_rd_stb);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clock);
            stable = stable & s_axi_rvalid & (s_axi_rdata == d) & (s_axi_rresp == r);
            stb_cnt += $countones(stat_rd_stb);
        end
        s_axi_rready = 1'b1;
        @(negedge clock);
        s_axi_rready = 1'b0;
        stable = stable & !s_axi_rvalid;
        stb_cnt += $countones(stat_rd_stb);
    endtask

    task automatic test_reset();
        logic [31:0] d, ed, ds; logic [1:0] r, er, rs; int lat, cnt; logic st; logic [NS-1:0] sf;
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_awprot = '0; s_axi_arprot = '0;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0;
        for (int j = 0; j < NS; j++) m_stat[j] = $urandom;
        for (int j = 0; j < NSS; j++) m_stat_s[j] = $urandom;
        load_stat();
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_bresp,
             s_axi_rresp, s_axi_rdata, cfg_wr_stb, stat_rd_stb} !== '0) begin
            errors++; $display("FAIL reset_outputs got awr=%b wr=%b bv=%b arr=%b rv=%b rdata=%h exp all 0",
                               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rdata);
        end
        checks++;
        if ({awready_s, wready_s, bvalid_s, arready_s, rvalid_s, bresp_s, rresp_s, rdata_s,
             cfg_wr_stb_s, stat_rd_stb_s, cfg_flat_s} !== '0) begin
            errors++; $display("FAIL reset_outputs_small got nonzero exp all 0");
        end
        checks++;
        if (cfg_flat !== '0) begin errors++; $display("FAIL reset_cfg got %h exp 0", cfg_flat[31:0]); end
        for (int i = 0; i < 32; i++) begin
            axi_read(7'(i*4), 0, d, r, ds, rs, lat, st, sf, cnt);
            exp_read(i, ed, er);
            checks++;
            if (d !== ed || r !== er) begin
                errors++; $display("FAIL reset_read[%0d] got %h/%b exp %h/%b", i, d, r, ed, er);
            end
            if (i == 0) begin
                checks++;
                if (lat !== 1) begin errors++; $display("FAIL read_latency got %0d exp 1", lat); end
            end
        end
    endtask

    task automatic test_strobe_write();
        logic [1:0] r, rs; int lat, vis; logic bv; logic [NC*32-1:0] ca, cv; logic [NC-1:0] sv, sn;
        axi_write(7'h0C, 32'h0, 4'hF, r, rs, lat, bv, vis, ca, cv, sv, sn);
        model_write(7'h0C, 32'h0, 4'hF);
        axi_write(7'h0C, 32'hAABBCCDD, 4'b0101, r, rs, lat, bv, vis, ca, cv, sv, sn);
        model_write(7'h0C, 32'hAABBCCDD, 4'b0101);
        checks++;
        if (cv[3*32 +: 32] !== 32'h00BB00DD) begin
            errors++; $display("FAIL strobe_value got %h exp 00bb00dd", cv[3*32 +: 32]);
        end
        checks++;
        if (ca[3*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL strobe_not_early got %h exp 0 in ack cycle", ca[3*32 +: 32]);
        end
        checks++;
        if (sv !== NC'(1 << 3) || sn !== '0) begin
            errors++; $display("FAIL wr_stb got %h then %h exp %h then 0", sv, sn, NC'(1 << 3));
        end
        checks++;
        if (r !== 2'b00 || bv !== 1'b1 || lat !== 1) begin
            errors++; $display("FAIL write_handshake got resp=%b bv=%b lat=%0d exp 00 1 1", r, bv, lat);
        end
    endtask

    task automatic test_random();
        logic [1:0] r, rs, er; int lat, vis, cnt; logic bv, st; logic [NC*32-1:0] ca, cv;
        logic [NC-1:0] sv, sn, esv; logic [31:0] d, ds, ed; logic [NS-1:0] sf;
        for (int n = 0; n < 40; n++) begin
            int idx = $urandom_range(1, 31);
            logic [31:0] wd = $urandom;
            logic [3:0] ws = 4'($urandom);
            axi_write(7'(idx*4), wd, ws, r, rs, lat, bv, vis, ca, cv, sv, sn);
            model_write(7'(idx*4), wd, ws);
            esv = (idx < NC) ? NC'(1) << idx : '0;
            checks++;
            if (r !== ((idx < NC) ? 2'b00 : 2'b10) || sv !== esv || lat !== 1) begin
                errors++; $display("FAIL rand_write[%0d] got resp=%b stb=%h lat=%0d exp stb %h", idx, r, sv, lat, esv);
            end
            if (n % 3 == 0) begin
                m_stat[$urandom_range(0, NS-1)] = $urandom;
                load_stat();
                idx = $urandom_range(1, 31);
                axi_read(7'(idx*4), $urandom_range(0, 2), d, r, ds, rs, lat, st, sf, cnt);
                exp_read(idx, ed, er);
                checks++;
                if (d !== ed || r !== er || st !== 1'b1) begin
                    errors++; $display("FAIL rand_read[%0d] got %h/%b exp %h/%b", idx, d, r, ed, er);
                end
            end
        end
    endtask

    task automatic pulse_wr(input logic [31:0] d, input logic [3:0] st);
        logic [1:0] r, rs; int lat, vis; logic bv; logic [NC*32-1:0] ca, cv; logic [NC-1:0] sv, sn;
        pulse_ev_t ev;
        axi_write(7'h00, d, st, r, rs, lat, bv, vis, ca, cv, sv, sn);
        model_write(7'h00, d, st);
        ev.vis = vis; ev.val = d[0];
        pq.push_back(ev);
    endtask

    task automatic test_pulse();
        int t0, t1, lat, cnt; logic exp_b, st; logic [31:0] d, ds; logic [1:0] r, rs; logic [NS-1:0] sf;
        pq.delete();
        t0 = cyc;
        pulse_wr(32'h56780000, 4'hF);
        pulse_wr(32'h12340001, 4'b0011);
        repeat (8) @(negedge clock);
        pulse_wr(32'h1, 4'b0001);
        pulse_wr(32'h1, 4'b0001);
        repeat (8) @(negedge clock);
        pulse_wr(32'h1, 4'b0001);
        pulse_wr(32'h0, 4'b0001);
        repeat (8) @(negedge clock);
        t1 = cyc;
        for (int t = t0; t < t1; t++) begin
            exp_b = 1'b0;
            foreach (pq[k]) if (pq[k].vis <= t) exp_b = pq[k].val && (t < pq[k].vis + PL);
            checks++;
            if (hist[t] !== exp_b) begin
                errors++; $display("FAIL pulse_bit cycle %0d got %b exp %b", t - t0, hist[t], exp_b);
            end
        end
        m_cfg[0][0] = 1'b0;
        m_cfg_s[0][0] = 1'b0;
        axi_read(7'h00, 0, d, r, ds, rs, lat, st, sf, cnt);
        checks++;
        if (d !== m_cfg[0] || r !== 2'b00) begin
            errors++; $display("FAIL reg0_nonmask got %h exp %h", d, m_cfg[0]);
        end
    endtask

    task automatic test_status_stall();
        logic [31:0] d, ds; logic [1:0] r, rs; int lat, cnt; logic st; logic [NS-1:0] sf;
        m_stat[0] = 32'h12345678;
        load_stat();
        axi_read(7'h50, 5, d, r, ds, rs, lat, st, sf, cnt);
        checks++;
        if (d !== 32'h12345678 || r !== 2'b00 || st !== 1'b1) begin
            errors++; $display("FAIL stat_stall got %h/%b stable=%b exp 12345678/00 stable=1", d, r, st);
        end
        checks++;
        if (sf !== NS'(1) || cnt !== 1) begin
            errors++; $display("FAIL stat_rd_stb got %h count %0d exp 001 count 1", sf, cnt);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r, rs, er; int lat, vis, cnt; logic bv, st; logic [NC*32-1:0] ca, cv;
        logic [NC-1:0] sv, sn; logic [31:0] d, ds, ed, sb; logic [NS-1:0] sf;
        sb = stat_flat[31:0];
        axi_write(7'h50, $urandom, 4'hF, r, rs, lat, bv, vis, ca, cv, sv, sn);
        checks++;
        if (r !== 2'b10 || sv !== '0 || cv !== ca) begin
            errors++; $display("FAIL stat_write got resp=%b stb=%h exp 10 stb 0 no change", r, sv);
        end
        axi_read(7'h50, 0, d, r, ds, rs, lat, st, sf, cnt);
        checks++;
        if (d !== sb || r !== 2'b00) begin
            errors++; $display("FAIL stat_after_write got %h/%b exp %h/00", d, r, sb);
        end
        axi_write(7'h10, 32'hCAFE0001, 4'hF, r, rs, lat, bv, vis, ca, cv, sv, sn);
        model_write(7'h10, 32'hCAFE0001, 4'hF);
        checks++;
        if (rs !== 2'b10 || r !== 2'b00) begin
            errors++; $display("FAIL small_stat_write got %b/%b exp 10/00", rs, r);
        end
        for (int i = 2; i < 32; i++) begin
            axi_read(7'(i*4), 0, d, r, ds, rs, lat, st, sf, cnt);
            exp_read_s(i, ed, er);
            checks++;
            if (ds !== ed || rs !== er) begin
                errors++; $display("FAIL small_read[%0d] got %h/%b exp %h/%b", i, ds, rs, ed, er);
            end
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] old_v, new_v, rd;
        old_v = m_cfg[7];
        new_v = $urandom;
        s_axi_awaddr = 7'h1C; s_axi_araddr = 7'h1C; s_axi_wdata = new_v; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
        @(negedge clock);
        checks++;
        if (!(s_axi_awready && s_axi_arready)) begin
            errors++; $display("FAIL concurrent_accept got aw=%b ar=%b exp 1 1", s_axi_awready, s_axi_arready);
        end
        @(negedge clock);
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        rd = s_axi_rdata;
        checks++;
        if (rd !== old_v || cfg_flat[7*32 +: 32] !== new_v) begin
            errors++; $display("FAIL concurrent got rd=%h reg=%h exp rd=%h reg=%h", rd, cfg_flat[7*32 +: 32], old_v, new_v);
        end
        model_write(7'h1C, new_v, 4'hF);
        s_axi_bready = 1; s_axi_rready = 1;
        @(negedge clock);
        s_axi_bready = 0; s_axi_rready = 0;
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] r, rs; int lat, vis, bseen; logic bv; logic [NC*32-1:0] ca, cv; logic [NC-1:0] sv, sn;
        s_axi_awaddr = 7'h14; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clock);
        checks++;
        if (s_axi_awready !== 1'b1) begin errors++; $display("FAIL mid_reset_ack got %b exp 1", s_axi_awready); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; s_axi_awvalid = 0; s_axi_wvalid = 0;
        model_reset();
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, cfg_wr_stb} !== '0 || cfg_flat !== '0) begin
            errors++; $display("FAIL mid_reset_state got awr=%b bv=%b reg5=%h exp 0", s_axi_awready, s_axi_bvalid, cfg_flat[5*32 +: 32]);
        end
        bseen = 0;
        repeat (6) begin @(negedge clock); if (s_axi_bvalid) bseen++; end
        checks++;
        if (bseen !== 0) begin errors++; $display("FAIL mid_reset_bvalid got %0d cycles exp 0", bseen); end
        axi_write(7'h14, 32'h0BADF00D, 4'hF, r, rs, lat, bv, vis, ca, cv, sv, sn);
        model_write(7'h14, 32'h0BADF00D, 4'hF);
        checks++;
        if (r !== 2'b00 || bv !== 1'b1 || lat !== 1 || cv[5*32 +: 32] !== m_cfg[5]) begin
            errors++; $display("FAIL post_reset_write got %h resp=%b exp %h resp=00", cv[5*32 +: 32], r, m_cfg[5]);
        end
    endtask

    initial begin
        test_reset();
        test_strobe_write();
        test_random();
        test_pulse();
        test_status_stall();
        test_slverr();
        test_concurrent();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
